// File: rtl/ring_phase_checker.sv
// ring_phase_checker
// Receive-side health monitor for a one-hot ring sequencer. Decodes the phase
// bus to a binary index, tracks whether successive samples follow the ring
// order bit0 -> bit1 -> ... -> bitN-1 -> bit0, declares lock after a run of
// correct steps, and counts completed rotations and in-lock violations.
module ring_phase_checker #(
   parameter int WIDTH      = 4,
   parameter int LOCK_COUNT = 4,
   parameter int REV_WIDTH  = 8,
   parameter int ERR_WIDTH  = 8,
   localparam int IW        = $clog2(WIDTH)
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iEn,
   input  logic [WIDTH-1:0]     iPhase,
   input  logic                 iClr,
   output logic [IW-1:0]        oIndex,
   output logic                 oValid,
   output logic                 oLocked,
   output logic                 oError,
   output logic [REV_WIDTH-1:0] oRevs,
   output logic [ERR_WIDTH-1:0] oErrCnt
);

   // The run counter must be able to hold LOCK_COUNT itself.
   localparam int CW = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] prev;
   logic [CW-1:0]    cnt;

   logic             sample_valid;
   logic [IW-1:0]    sample_index;
   logic             is_succ;
   logic             is_wrap;

   // True when exactly one bit of v is set.
   function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            if (seen) begin
               multi = 1'b1;
            end else begin
               seen = 1'b1;
            end
         end
      end
      return seen & ~multi;
   endfunction

   // Bit position of the set bit; only meaningful for a one-hot input.
   function automatic logic [IW-1:0] encode(input logic [WIDTH-1:0] v);
      logic [IW-1:0] idx;
      idx = {IW{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            idx = IW'(i);
         end
      end
      return idx;
   endfunction

   // Ring successor: rotate left by one, top bit wraps into bit 0.
   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[WIDTH-1]};
   endfunction

   // Classify the current sample against the previously accepted phase.
   always_comb begin
      sample_valid = is_one_hot(iPhase);
      sample_index = encode(iPhase);
      if (sample_valid && (iPhase == rotl(prev))) begin
         is_succ = 1'b1;
      end else begin
         is_succ = 1'b0;
      end
      is_wrap = is_succ & iPhase[0];
   end

   // Lock FSM, decoded outputs and rotation/error counters; clear wins last.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state   <= UNLOCKED;
         prev    <= {WIDTH{1'b0}};
         cnt     <= {CW{1'b0}};
         oIndex  <= {IW{1'b0}};
         oValid  <= 1'b0;
         oLocked <= 1'b0;
         oError  <= 1'b0;
         oRevs   <= {REV_WIDTH{1'b0}};
         oErrCnt <= {ERR_WIDTH{1'b0}};
      end else begin
         oError <= 1'b0;
         if (iEn) begin
            oValid <= sample_valid;
            if (sample_valid) begin
               oIndex <= sample_index;
            end
            case (state)
               UNLOCKED: begin
                  if (sample_valid) begin
                     prev  <= iPhase;
                     cnt   <= {CW{1'b0}};
                     state <= ACQUIRE;
                  end
               end
               ACQUIRE: begin
                  if (is_succ) begin
                     prev <= iPhase;
                     cnt  <= cnt + CW'(1);
                     // Entering lock never counts a wrap, even on bit 0.
                     if (cnt == CW'(LOCK_COUNT - 1)) begin
                        state   <= LOCKED;
                        oLocked <= 1'b1;
                     end
                  end else if (sample_valid) begin
                     prev <= iPhase;
                     cnt  <= {CW{1'b0}};
                  end else begin
                     cnt   <= {CW{1'b0}};
                     state <= UNLOCKED;
                  end
               end
               LOCKED: begin
                  if (is_succ) begin
                     prev <= iPhase;
                     if (is_wrap) begin
                        oRevs <= oRevs + REV_WIDTH'(1);
                     end
                  end else begin
                     oError  <= 1'b1;
                     oLocked <= 1'b0;
                     cnt     <= {CW{1'b0}};
                     if (oErrCnt != {ERR_WIDTH{1'b1}}) begin
                        oErrCnt <= oErrCnt + ERR_WIDTH'(1);
                     end
                     if (sample_valid) begin
                        prev  <= iPhase;
                        state <= ACQUIRE;
                     end else begin
                        state <= UNLOCKED;
                     end
                  end
               end
               default: begin
                  state   <= UNLOCKED;
                  cnt     <= {CW{1'b0}};
                  oLocked <= 1'b0;
               end
            endcase
         end
         if (iClr) begin
            oRevs   <= {REV_WIDTH{1'b0}};
            oErrCnt <= {ERR_WIDTH{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_ring_phase_checker.sv
// Self-checking bench for ring_phase_checker: directed scenarios plus random
// traffic, each cycle's expectation computed by an index-arithmetic model and
// queued for a monitor that compares it with the DUT on the falling edge.
module tb_ring_phase_checker;

   logic       iClk;
   logic       iRst;
   logic       iEn;
   logic [3:0] iPhase;
   logic       iClr;
   logic [1:0] oIndex;
   logic       oValid;
   logic       oLocked;
   logic       oError;
   logic [7:0] oRevs;
   logic [7:0] oErrCnt;

   ring_phase_checker #(
      .WIDTH(4), .LOCK_COUNT(4), .REV_WIDTH(8), .ERR_WIDTH(8)
   ) dut (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iPhase(iPhase), .iClr(iClr),
      .oIndex(oIndex), .oValid(oValid), .oLocked(oLocked), .oError(oError),
      .oRevs(oRevs), .oErrCnt(oErrCnt)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   typedef struct packed {
      logic [1:0] idx;
      logic       valid;
      logic       locked;
      logic       err;
      logic [7:0] revs;
      logic [7:0] errcnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: positions on a ring of 4, run length of correct steps.
   bit m_has_prev;
   int m_prev;
   int m_run;
   bit m_locked;
   int m_idx;
   bit m_valid;
   bit m_err;
   int m_revs;
   int m_errcnt;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_has_prev = 0; m_prev = 0; m_run = 0; m_locked = 0;
      m_idx = 0; m_valid = 0; m_err = 0; m_revs = 0; m_errcnt = 0;
   endfunction

   function automatic void model_step(input bit en, input logic [3:0] ph, input bit clr);
      bit v;
      int pos;
      bit succ;
      m_err = 0;
      if (en) begin
         v = ($countones(ph) == 1);
         pos = 0;
         for (int i = 0; i < 4; i++) if (ph[i]) pos = i;
         succ = v && m_has_prev && (pos == (m_prev + 1) % 4);
         m_valid = v;
         if (v) m_idx = pos;
         if (m_locked) begin
            if (succ) begin
               m_prev = pos;
               if (pos == 0) m_revs = (m_revs + 1) % 256;
            end else begin
               m_err = 1;
               if (m_errcnt < 255) m_errcnt++;
               m_locked = 0;
               m_run = 0;
               m_has_prev = v;
               if (v) m_prev = pos;
            end
         end else if (!v) begin
            m_has_prev = 0;
            m_run = 0;
         end else if (succ) begin
            m_prev = pos;
            m_run++;
            if (m_run == 4) m_locked = 1;
         end else begin
            m_has_prev = 1;
            m_prev = pos;
            m_run = 0;
         end
      end
      if (clr) begin
         m_revs = 0;
         m_errcnt = 0;
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.idx = 2'(m_idx); e.valid = m_valid; e.locked = m_locked; e.err = m_err;
      e.revs = 8'(m_revs); e.errcnt = 8'(m_errcnt);
      return e;
   endfunction

   // Monitor: compare the oldest queued expectation with the DUT outputs.
   always @(negedge iClk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("index",  int'(oIndex),  int'(e.idx));
         check("valid",  int'(oValid),  int'(e.valid));
         check("locked", int'(oLocked), int'(e.locked));
         check("error",  int'(oError),  int'(e.err));
         check("revs",   int'(oRevs),   int'(e.revs));
         check("errcnt", int'(oErrCnt), int'(e.errcnt));
      end
   end

   logic [3:0] last_ph = 4'b0001;

   task automatic step(input logic en, input logic [3:0] ph, input logic clr);
      @(negedge iClk);
      #1;
      iRst = 1'b0; iEn = en; iPhase = ph; iClr = clr;
      last_ph = ph;
      @(posedge iClk);
      model_step(en, ph, clr);
      exp_q.push_back(model_out());
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_index"},  int'(oIndex),  0);
      check({tag, "_valid"},  int'(oValid),  0);
      check({tag, "_locked"}, int'(oLocked), 0);
      check({tag, "_error"},  int'(oError),  0);
      check({tag, "_revs"},   int'(oRevs),   0);
      check({tag, "_errcnt"}, int'(oErrCnt), 0);
   endtask

   // Assert reset between edges, check the outputs clear at once, hold one cycle.
   task automatic reset_mid();
      #2;
      iRst = 1'b1;
      #1;
      check_zero("async_rst");
      model_reset();
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(model_out());
      @(negedge iClk);
      #1;
      @(posedge iClk);
      exp_q.push_back(model_out());
   endtask

   task automatic lock_from_one();
      step(1'b1, 4'b0001, 1'b0);
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b0100, 1'b0);
      step(1'b1, 4'b1000, 1'b0);
      step(1'b1, 4'b0001, 1'b0);
   endtask

   initial begin
      logic [3:0] seq9 [9];
      seq9 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
               4'b0010, 4'b0100, 4'b1000, 4'b0001};
      iRst = 1'b1; iEn = 1'b1; iPhase = 4'b0100; iClr = 1'b0;
      model_reset();
      #1;
      check_zero("reset");
      for (int i = 0; i < 2; i++) begin
         @(posedge iClk);
         exp_q.push_back(model_out());
      end

      // Lock and count.
      for (int i = 0; i < 9; i++) begin
         step(1'b1, seq9[i], 1'b0);
         #1;
         check("lock_seq_index", int'(oIndex), i % 4);
         check("lock_seq_locked", int'(oLocked), (i >= 4) ? 1 : 0);
      end
      check("revs_after_9", int'(oRevs), 1);

      // Skip while locked.
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b1000, 1'b0);
      #1;
      check("skip_error", int'(oError), 1);
      check("skip_errcnt", int'(oErrCnt), 1);
      check("skip_locked", int'(oLocked), 0);
      step(1'b1, 4'b0001, 1'b0);
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b0100, 1'b0);
      step(1'b1, 4'b1000, 1'b0);
      #1;
      check("relock", int'(oLocked), 1);

      // Invalid code while locked.
      step(1'b1, 4'b0001, 1'b0);
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b0110, 1'b0);
      #1;
      check("inval_error", int'(oError), 1);
      check("inval_valid", int'(oValid), 0);
      check("inval_index", int'(oIndex), 1);
      check("inval_locked", int'(oLocked), 0);
      step(1'b1, 4'b0000, 1'b0);
      #1;
      check("zero_no_error", int'(oError), 0);

      // Enable low holds everything.
      lock_from_one();
      for (int i = 0; i < 3; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      #1;
      check("hold_locked", int'(oLocked), 1);

      // Preset to 255 wraps, then clear colliding with a wrap; then 256 wraps.
      step(1'b1, 4'b0010, 1'b1);
      for (int i = 0; i < 255; i++) begin
         step(1'b1, 4'b0100, 1'b0);
         step(1'b1, 4'b1000, 1'b0);
         step(1'b1, 4'b0001, 1'b0);
         step(1'b1, 4'b0010, 1'b0);
      end
      #1;
      check("revs_255", int'(oRevs), 255);
      step(1'b1, 4'b0100, 1'b0);
      step(1'b1, 4'b1000, 1'b0);
      step(1'b1, 4'b0001, 1'b1);
      #1;
      check("clr_wins", int'(oRevs), 0);
      for (int i = 0; i < 256; i++) begin
         step(1'b1, 4'b0010, 1'b0);
         step(1'b1, 4'b0100, 1'b0);
         step(1'b1, 4'b1000, 1'b0);
         step(1'b1, 4'b0001, 1'b0);
      end
      #1;
      check("revs_wrap_256", int'(oRevs), 0);

      // Asynchronous reset while locked.
      reset_mid();

      // Error counter saturation.
      lock_from_one();
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 4'b0100, 1'b0);
         step(1'b1, 4'b1000, 1'b0);
         step(1'b1, 4'b0001, 1'b0);
         step(1'b1, 4'b0010, 1'b0);
         step(1'b1, 4'b0100, 1'b0);
      end
      #1;
      check("errcnt_sat", int'(oErrCnt), 255);

      // Random traffic, biased toward ring order so lock is reached often.
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [3:0] ph;
         int pos;
         r = $urandom_range(0, 99);
         pos = 0;
         for (int k = 0; k < 4; k++) if (last_ph[k]) pos = k;
         if (r < 70) ph = 4'(1 << ((pos + 1) % 4));
         else if (r < 80) ph = 4'(1 << $urandom_range(0, 3));
         else if (r < 90) ph = 4'($urandom_range(0, 15));
         else ph = last_ph;
         step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, ph,
              ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
         if ($urandom_range(0, 499) == 0) reset_mid();
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge iClk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
